// File: rtl/c1541_track_loader.sv
// Keeps the GCR stage's track buffer holding the D64 sectors of the head track, flushing a dirty buffer before reloading.
// busy rises 1 cycle after a track change and falls 1 cycle after the last load ack; each block waits on sd_ack rise then fall.
module c1541_track_loader #(
  parameter int SETTLE_CYCLES = 160000,
  parameter int MAX_TRACK     = 35
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [5:0]  track,
  input  logic        buf_we,
  output logic        busy,
  output logic [31:0] sd_lba,
  output logic [4:0]  sd_sector,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [5:0]    MAX_T       = 6'(MAX_TRACK);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_FLUSH, S_LOAD, S_READY} state_t;
  typedef enum logic [1:0] {PH_ISSUE, PH_REQ, PH_ACK} phase_t;

  state_t        state;
  phase_t        phase;
  logic [CW-1:0] cnt;
  logic [5:0]    track_q;
  logic [5:0]    ltrk;
  logic [5:0]    otrk;
  logic [4:0]    sec;
  logic          dirty;
  logic          remount;
  logic [5:0]    trk_c;
  logic [5:0]    xtrk;
  logic [4:0]    last_sec;

  function automatic logic [5:0] clamp_trk(input logic [5:0] t);
    if (t == 6'd0)       clamp_trk = 6'd1;
    else if (t > MAX_T)  clamp_trk = MAX_T;
    else                 clamp_trk = t;
  endfunction

  function automatic logic [4:0] trk_spt(input logic [5:0] t);
    if (t <= 6'd17)      trk_spt = 5'd21;
    else if (t <= 6'd24) trk_spt = 5'd19;
    else if (t <= 6'd30) trk_spt = 5'd18;
    else                 trk_spt = 5'd17;
  endfunction

  function automatic logic [9:0] trk_start(input logic [5:0] t);
    logic [9:0] tt;
    tt = {4'd0, t};
    if (t <= 6'd17)      trk_start = (tt - 10'd1) * 10'd21;
    else if (t <= 6'd24) trk_start = 10'd357 + (tt - 10'd18) * 10'd19;
    else if (t <= 6'd30) trk_start = 10'd490 + (tt - 10'd25) * 10'd18;
    else                 trk_start = 10'd598 + (tt - 10'd31) * 10'd17;
  endfunction

  // A flush writes back the previously loaded track, a load reads the latched one.
  assign trk_c    = clamp_trk(track);
  assign xtrk     = (state == S_FLUSH) ? otrk : ltrk;
  assign last_sec = trk_spt(xtrk) - 5'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      phase     <= PH_ISSUE;
      cnt       <= '0;
      track_q   <= '0;
      ltrk      <= '0;
      otrk      <= '0;
      sec       <= '0;
      dirty     <= 1'b0;
      remount   <= 1'b0;
      busy      <= 1'b0;
      sd_lba    <= '0;
      sd_sector <= '0;
      sd_rd     <= 1'b0;
      sd_wr     <= 1'b0;
    end else begin
      track_q <= track;
      case (state)
        S_IDLE: begin
          if (img_mounted) begin
            state <= S_SETTLE;
            cnt   <= '0;
            dirty <= 1'b0;
            busy  <= 1'b1;
          end
        end

        S_SETTLE: begin
          if (img_mounted) begin
            dirty <= 1'b0;
            cnt   <= '0;
          end else if (track != track_q) begin
            cnt <= '0;
          end else if (cnt == SETTLE_LAST) begin
            ltrk    <= trk_c;
            sec     <= '0;
            phase   <= PH_ISSUE;
            cnt     <= '0;
            remount <= 1'b0;
            if (dirty && !img_readonly) begin
              state <= S_FLUSH;
            end else begin
              state <= S_LOAD;
              dirty <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_FLUSH, S_LOAD: begin
          // A new image invalidates everything; the block in flight is still completed.
          if (img_mounted) begin
            remount <= 1'b1;
            dirty   <= 1'b0;
          end
          case (phase)
            PH_ISSUE: begin
              if (remount || img_mounted) begin
                state   <= S_SETTLE;
                cnt     <= '0;
                remount <= 1'b0;
              end else begin
                sd_sector <= sec;
                sd_lba    <= {22'd0, trk_start(xtrk) + {5'd0, sec}};
                sd_rd     <= (state == S_LOAD);
                sd_wr     <= (state == S_FLUSH);
                phase     <= PH_REQ;
              end
            end
            PH_REQ: begin
              if (sd_ack) begin
                sd_rd <= 1'b0;
                sd_wr <= 1'b0;
                phase <= PH_ACK;
              end
            end
            PH_ACK: begin
              if (!sd_ack) begin
                phase <= PH_ISSUE;
                if (remount || img_mounted) begin
                  state   <= S_SETTLE;
                  cnt     <= '0;
                  remount <= 1'b0;
                end else if (state == S_LOAD && trk_c != ltrk) begin
                  state <= S_SETTLE;
                  cnt   <= '0;
                end else if (sec == last_sec) begin
                  sec <= '0;
                  if (state == S_FLUSH) begin
                    dirty <= 1'b0;
                    if (trk_c != ltrk) begin
                      state <= S_SETTLE;
                      cnt   <= '0;
                    end else begin
                      state <= S_LOAD;
                    end
                  end else begin
                    state <= S_READY;
                    otrk  <= ltrk;
                    busy  <= 1'b0;
                  end
                end else begin
                  sec <= sec + 1'b1;
                end
              end
            end
            default: phase <= PH_ISSUE;
          endcase
        end

        S_READY: begin
          if (img_mounted) begin
            state <= S_SETTLE;
            cnt   <= '0;
            dirty <= 1'b0;
            busy  <= 1'b1;
          end else begin
            if (buf_we) dirty <= 1'b1;
            if (trk_c != otrk) begin
              state <= S_SETTLE;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c1541_track_loader.sv
// Directed bench for c1541_track_loader with a small SD host that acks each block and logs every request.
module tb_c1541_track_loader;
  logic        clk = 1'b0;
  logic        reset_n, img_mounted, img_readonly, buf_we, sd_ack;
  logic [5:0]  track;
  logic        busy, sd_rd, sd_wr;
  logic [31:0] sd_lba;
  logic [4:0]  sd_sector;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_ack_fall = 0;
  int busy_low_cyc = 0;
  int proto_err = 0;
  int busy_lo_xfer = 0;
  bit tmo;

  logic        log_rd[$];
  logic [31:0] log_lba[$];
  logic [4:0]  log_sec[$];

  c1541_track_loader #(.SETTLE_CYCLES(4), .MAX_TRACK(35)) dut (
    .clk(clk), .reset_n(reset_n), .img_mounted(img_mounted), .img_readonly(img_readonly),
    .track(track), .buf_we(buf_we), .busy(busy), .sd_lba(sd_lba), .sd_sector(sd_sector),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SD host: logs a request, acks two cycles later, drops ack one cycle after the request falls.
  initial begin : host
    sd_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (sd_rd === 1'b1 && sd_wr === 1'b1) proto_err++;
      if (sd_rd === 1'b1 || sd_wr === 1'b1) begin
        if (busy !== 1'b1) busy_lo_xfer++;
        log_rd.push_back(sd_rd);
        log_lba.push_back(sd_lba);
        log_sec.push_back(sd_sector);
        repeat (2) @(negedge clk);
        if (reset_n === 1'b1 && sd_rd !== 1'b1 && sd_wr !== 1'b1) proto_err++;
        sd_ack = 1'b1;
        for (int i = 0; i < 50 && (sd_rd === 1'b1 || sd_wr === 1'b1); i++) @(negedge clk);
        @(negedge clk);
        sd_ack = 1'b0;
        last_ack_fall = cyc;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic clear_log();
    log_rd.delete();
    log_lba.delete();
    log_sec.delete();
  endtask

  task automatic pulse_mount();
    img_mounted = 1'b1;
    @(negedge clk);
    img_mounted = 1'b0;
  endtask

  task automatic pulse_we();
    buf_we = 1'b1;
    @(negedge clk);
    buf_we = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    while ((busy !== 1'b0 || sd_ack !== 1'b0) && n < 4000) begin @(negedge clk); n++; end
    busy_low_cyc = cyc;
    tmo = (n >= 4000);
  endtask

  task automatic wait_log(input int k);
    int n;
    n = 0;
    while (log_rd.size() < k && n < 2000) begin @(negedge clk); n++; end
    tmo = (n >= 2000);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (sd_rd !== 1'b0 || sd_wr !== 1'b0) begin n_fail++; $display("FAIL rst_req: got rd=%b wr=%b want 0/0", sd_rd, sd_wr); end
    n_cmp++; if (sd_lba !== 32'd0) begin n_fail++; $display("FAIL rst_lba: got %0d want 0", sd_lba); end
    n_cmp++; if (sd_sector !== 5'd0) begin n_fail++; $display("FAIL rst_sector: got %0d want 0", sd_sector); end
    reset_n = 1'b1;
    clear_log();
    repeat (12) @(negedge clk);
    n_cmp++; if (log_rd.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_quiet: got %0d requests busy=%b want 0/0", log_rd.size(), busy); end
  endtask

  task automatic test_mount();
    clear_log();
    track = 6'd1;
    pulse_mount();
    wait_ready();
    n_cmp++; if (tmo) begin n_fail++; $display("FAIL mount_timeout: got timeout want busy low"); end
    n_cmp++; if (log_rd.size() != 21) begin n_fail++; $display("FAIL mount_count: got %0d want 21", log_rd.size()); end
    for (int i = 0; i < log_rd.size(); i++) begin
      n_cmp++;
      if (log_rd[i] !== 1'b1 || log_lba[i] !== 32'(i) || log_sec[i] !== 5'(i)) begin
        n_fail++; $display("FAIL mount_blk%0d: got rd=%b lba=%0d sec=%0d want rd=1 lba=%0d sec=%0d", i, log_rd[i], log_lba[i], log_sec[i], i, i);
      end
    end
    n_cmp++; if (busy_low_cyc - last_ack_fall != 1) begin n_fail++; $display("FAIL busy_fall_latency: got %0d want 1", busy_low_cyc - last_ack_fall); end
  endtask

  task automatic test_track_change_clean();
    clear_log();
    track = 6'd17;
    wait_ready();
    n_cmp++; if (tmo || log_rd.size() != 21) begin n_fail++; $display("FAIL t17_count: got %0d tmo=%b want 21", log_rd.size(), tmo); end
    for (int i = 0; i < log_rd.size(); i++) begin
      n_cmp++;
      if (log_rd[i] !== 1'b1 || log_lba[i] !== 32'(336 + i) || log_sec[i] !== 5'(i)) begin
        n_fail++; $display("FAIL t17_blk%0d: got rd=%b lba=%0d sec=%0d want rd=1 lba=%0d sec=%0d", i, log_rd[i], log_lba[i], log_sec[i], 336 + i, i);
      end
    end
    clear_log();
    track = 6'd18;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_rise_latency: got %b want 1", busy); end
    wait_ready();
    n_cmp++; if (tmo || log_rd.size() != 19) begin n_fail++; $display("FAIL t18_count: got %0d tmo=%b want 19", log_rd.size(), tmo); end
    for (int i = 0; i < log_rd.size(); i++) begin
      n_cmp++;
      if (log_rd[i] !== 1'b1 || log_lba[i] !== 32'(357 + i) || log_sec[i] !== 5'(i)) begin
        n_fail++; $display("FAIL t18_blk%0d: got rd=%b lba=%0d sec=%0d want rd=1 lba=%0d sec=%0d", i, log_rd[i], log_lba[i], log_sec[i], 357 + i, i);
      end
    end
  endtask

  task automatic test_flush();
    clear_log();
    pulse_we();
    track = 6'd25;
    wait_ready();
    n_cmp++; if (tmo || log_rd.size() != 37) begin n_fail++; $display("FAIL flush_count: got %0d tmo=%b want 37", log_rd.size(), tmo); end
    for (int i = 0; i < log_rd.size(); i++) begin
      logic        e_rd;
      logic [31:0] e_lba;
      logic [4:0]  e_sec;
      e_rd  = (i >= 19);
      e_lba = (i < 19) ? 32'(357 + i) : 32'(490 + i - 19);
      e_sec = (i < 19) ? 5'(i) : 5'(i - 19);
      n_cmp++;
      if (log_rd[i] !== e_rd || log_lba[i] !== e_lba || log_sec[i] !== e_sec) begin
        n_fail++; $display("FAIL flush_blk%0d: got rd=%b lba=%0d sec=%0d want rd=%b lba=%0d sec=%0d", i, log_rd[i], log_lba[i], log_sec[i], e_rd, e_lba, e_sec);
      end
    end
  endtask

  task automatic test_readonly();
    track = 6'd18;
    wait_ready();
    clear_log();
    pulse_we();
    img_readonly = 1'b1;
    track = 6'd25;
    wait_ready();
    n_cmp++; if (tmo || log_rd.size() != 18) begin n_fail++; $display("FAIL ro_count: got %0d tmo=%b want 18", log_rd.size(), tmo); end
    for (int i = 0; i < log_rd.size(); i++) begin
      n_cmp++;
      if (log_rd[i] !== 1'b1 || log_lba[i] !== 32'(490 + i) || log_sec[i] !== 5'(i)) begin
        n_fail++; $display("FAIL ro_blk%0d: got rd=%b lba=%0d sec=%0d want rd=1 lba=%0d sec=%0d", i, log_rd[i], log_lba[i], log_sec[i], 490 + i, i);
      end
    end
    // The load cleared dirty, so leaving write protect must not flush anything.
    img_readonly = 1'b0;
    clear_log();
    track = 6'd26;
    wait_ready();
    n_cmp++; if (tmo || log_rd.size() != 18) begin n_fail++; $display("FAIL ro_clear_count: got %0d tmo=%b want 18", log_rd.size(), tmo); end
    n_cmp++; if (log_rd.size() > 0 && (log_rd[0] !== 1'b1 || log_lba[0] !== 32'd508)) begin n_fail++; $display("FAIL ro_clear_first: got rd=%b lba=%0d want rd=1 lba=508", log_rd[0], log_lba[0]); end
  endtask

  task automatic test_mid_load_change();
    clear_log();
    track = 6'd20;
    wait_log(6);
    n_cmp++; if (tmo) begin n_fail++; $display("FAIL midload_wait: got timeout want 6 requests"); end
    track = 6'd21;
    wait_ready();
    n_cmp++; if (tmo || log_rd.size() != 25) begin n_fail++; $display("FAIL midload_count: got %0d tmo=%b want 25", log_rd.size(), tmo); end
    for (int i = 0; i < log_rd.size(); i++) begin
      logic [31:0] e_lba;
      logic [4:0]  e_sec;
      e_lba = (i < 6) ? 32'(395 + i) : 32'(414 + i - 6);
      e_sec = (i < 6) ? 5'(i) : 5'(i - 6);
      n_cmp++;
      if (log_rd[i] !== 1'b1 || log_lba[i] !== e_lba || log_sec[i] !== e_sec) begin
        n_fail++; $display("FAIL midload_blk%0d: got rd=%b lba=%0d sec=%0d want rd=1 lba=%0d sec=%0d", i, log_rd[i], log_lba[i], log_sec[i], e_lba, e_sec);
      end
    end
  endtask

  task automatic test_clamp();
    clear_log();
    track = 6'd40;
    wait_ready();
    n_cmp++; if (tmo || log_rd.size() != 17) begin n_fail++; $display("FAIL clamp35_count: got %0d tmo=%b want 17", log_rd.size(), tmo); end
    for (int i = 0; i < log_rd.size(); i++) begin
      n_cmp++;
      if (log_rd[i] !== 1'b1 || log_lba[i] !== 32'(666 + i) || log_sec[i] !== 5'(i)) begin
        n_fail++; $display("FAIL clamp35_blk%0d: got rd=%b lba=%0d sec=%0d want rd=1 lba=%0d sec=%0d", i, log_rd[i], log_lba[i], log_sec[i], 666 + i, i);
      end
    end
    clear_log();
    track = 6'd0;
    wait_ready();
    n_cmp++; if (tmo || log_rd.size() != 21) begin n_fail++; $display("FAIL clamp0_count: got %0d tmo=%b want 21", log_rd.size(), tmo); end
    n_cmp++; if (log_rd.size() == 21 && (log_lba[0] !== 32'd0 || log_lba[20] !== 32'd20)) begin n_fail++; $display("FAIL clamp0_lba: got %0d..%0d want 0..20", log_lba[0], log_lba[20]); end
  endtask

  task automatic test_remount();
    // Remount from READY with a dirty buffer: the old image must not be written.
    clear_log();
    pulse_we();
    pulse_mount();
    wait_ready();
    n_cmp++; if (tmo || log_rd.size() != 21) begin n_fail++; $display("FAIL remount_count: got %0d tmo=%b want 21", log_rd.size(), tmo); end
    for (int i = 0; i < log_rd.size(); i++) begin
      n_cmp++;
      if (log_rd[i] !== 1'b1 || log_lba[i] !== 32'(i)) begin
        n_fail++; $display("FAIL remount_blk%0d: got rd=%b lba=%0d want rd=1 lba=%0d", i, log_rd[i], log_lba[i], i);
      end
    end
    clear_log();
    pulse_mount();
    wait_log(3);
    pulse_mount();
    wait_ready();
    n_cmp++; if (tmo || log_rd.size() != 24) begin n_fail++; $display("FAIL remount_mid_count: got %0d tmo=%b want 24", log_rd.size(), tmo); end
    for (int i = 0; i < log_rd.size(); i++) begin
      logic [31:0] e_lba;
      e_lba = (i < 3) ? 32'(i) : 32'(i - 3);
      n_cmp++;
      if (log_rd[i] !== 1'b1 || log_lba[i] !== e_lba) begin
        n_fail++; $display("FAIL remount_mid_blk%0d: got rd=%b lba=%0d want rd=1 lba=%0d", i, log_rd[i], log_lba[i], e_lba);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    n = 0;
    track = 6'd5;
    while (sd_rd !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_cmp++; if (n >= 200) begin n_fail++; $display("FAIL rstmid_wait: got no read want sd_rd=1"); end
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (sd_rd !== 1'b0 || sd_wr !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got rd=%b wr=%b want 0/0", sd_rd, sd_wr); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    clear_log();
    repeat (12) @(negedge clk);
    n_cmp++; if (log_rd.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got %0d requests busy=%b want 0/0", log_rd.size(), busy); end
  endtask

  task automatic test_protocol();
    n_cmp++; if (proto_err != 0) begin n_fail++; $display("FAIL handshake: got %0d violations want 0", proto_err); end
    n_cmp++; if (busy_lo_xfer != 0) begin n_fail++; $display("FAIL busy_in_xfer: got %0d requests with busy low want 0", busy_lo_xfer); end
  endtask

  initial begin
    reset_n      = 1'b0;
    img_mounted  = 1'b0;
    img_readonly = 1'b0;
    buf_we       = 1'b0;
    track        = 6'd1;
    @(negedge clk);
    test_reset();
    test_mount();
    test_track_change_clean();
    test_flush();
    test_readonly();
    test_mid_load_change();
    test_clamp();
    test_remount();
    test_protocol();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
